sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised per-pixel sprite mixer that replaces the fixed ship/rock/shot colour mapping with NUM_SPRITES generic layers. It sits between the game-state modules (ship, rock and shot status) and the VGA controller. Per-sprite position and size are latched once per frame into shadow registers. Each pixel passes through a fixed-latency pipeline: hit test, priority, texture fetch, mix. The block also accumulates a pairwise bounding-box collision matrix for game_control, published once per frame.

## Interface
- NUM_SPRITES, 8: sprite layers; index 0 has highest priority.
- COORD_W, 10: DrawX/DrawY and sprite coordinate width.
- HALF_MAX, 32: largest legal half-size; local coordinate width LOC_W = $clog2(2*HALF_MAX+1).
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pix_valid  in  1  DrawX/DrawY valid this cycle (active video).
- DrawX, DrawY  in  COORD_W each  current pixel.
- sprite_x, sprite_y  in  NUM_SPRITES*COORD_W  sprite centres, packed with sprite i at [i*COORD_W +: COORD_W].
- sprite_half  in  NUM_SPRITES*LOC_W  half-size per sprite.
- sprite_en  in  NUM_SPRITES  sprite exists.
- sprite_tex  in  NUM_SPRITES  1 = textured, 0 = solid colour.
- sprite_rgb  in  NUM_SPRITES*24  solid colour per sprite, {R,G,B}.
- tex_id  out  $clog2(NUM_SPRITES)  texture request: winning sprite.
- tex_row, tex_col  out  LOC_W  texture request: local coordinates.
- tex_rgb  in  24  texture ROM data, valid one cycle after the request.
- tex_alpha  in  1  texture ROM data; 0 = transparent.
- Red, Green, Blue  out  8 each  mixed pixel.
- out_valid  out  1  delayed pix_valid.
- coll_flags  out  NUM_SPRITES*(NUM_SPRITES-1)/2  pairwise collisions from the previous frame.
- coll_valid  out  1  one-cycle pulse when coll_flags updates.

## Operation
- Shadow registers:
  - On frame_start, sprite_x, sprite_y, sprite_half, sprite_en, sprite_tex and sprite_rgb are copied into shadow registers.
  - The live inputs are ignored at all other times.
  - Game logic may change the inputs mid-frame without tearing.
- S1, hit test:
  - hit[i] = en[i] and DrawX in [x[i]-half[i], x[i]+half[i]] inclusive, and the same for Y.
  - All arithmetic is signed, COORD_W+2 bits wide, so boxes touching coordinate 0 or 2^COORD_W-1 do not wrap.
  - The hit mask is registered.
- S2, priority:
  - The lowest set index of the hit mask wins.
  - Register the winner id, local col = DrawX-x+half and local row = DrawY-y+half (range 0..2*half), any_hit, and the winner's tex and rgb.
  - Drive tex_id, tex_row and tex_col from these registers.
- S3: the external synchronous ROM returns tex_rgb/tex_alpha.
- S4, mix:
  - any_hit and solid: output the winner's rgb.
  - any_hit, textured, tex_alpha=1: output tex_rgb.
  - Otherwise output the background: R=0, G=0, B=8'h7F-DrawX[9:3], using DrawX delayed to S4.
  - Transparent texels show background, not lower-priority sprites.
  - When out_valid is 0, RGB is 0.
- Collision accumulation:
  - For every S1 pixel with pix_valid, for each pair i<j with hit[i]&hit[j], set acc[j*(j-1)/2+i].
  - On frame_start: coll_flags <= acc | (pairs detected on the same edge), acc <= 0, coll_valid = 1 for one cycle.

## Timing
- Latency: a pixel sampled on edge n produces Red/Green/Blue/out_valid registered on edge n+4. tex_* is registered on edge n+2.
- Throughput is one pixel per clock with no stalls. pix_valid gaps propagate as out_valid gaps.
- Reset: shadow registers, acc, coll_flags, coll_valid, out_valid, RGB, tex_* and all pipeline registers are 0. With sprite_en shadow 0, only background is drawn until the first frame_start.
- frame_start together with pix_valid: new shadows apply to pixels sampled from edge n+1. The pixel on edge n is tested with the old shadows and accumulated into the new frame's acc.
- Reset_n asserted mid-frame clears the pipeline immediately. Output resumes 4 edges after the first valid pixel following reset.

## Configuration
- SPRITE_COLLISION_EN defined: collision accumulation, coll_flags and coll_valid are implemented as described.
- SPRITE_COLLISION_EN undefined: no accumulator logic; coll_flags and coll_valid are tied to 0. Pixel path and latency are unchanged.

## Structure
- Package sprite_pkg:
  - rgb_t, a packed struct {R,G,B} of 8 bits each.
  - Default NUM_SPRITES, COORD_W, HALF_MAX.
  - pair_idx(i,j) function.
  - BG_BLUE_BASE = 8'h7F.
- Sub-module sprite_hit_test: one instance per sprite via generate. Computes the signed box compare and the local row/col.

## Test plan
- Reset, then pix_valid with DrawX=80, no frame_start -> after 4 edges out_valid=1, RGB = 00,00,0x75.
- Sprite 0 solid at (100,100), half=2, rgb=FFFFFF, frame_start, DrawX=102/DrawY=98 -> FFFFFF. DrawX=103 -> background.
- Sprites 0 and 1 overlap at (50,50), pixel inside both -> tex_id=0. Next frame_start -> coll_flags bit 0 = 1 and coll_valid pulses once.
- Textured sprite 2 at (5,5), half=32, DrawX=0/DrawY=0 -> hit with tex_col=27, tex_row=27, no wrap. Returning tex_alpha=0 -> background.
- Change sprite_x mid-frame without frame_start -> output unchanged until the next frame_start.
- Reset_n pulsed with 3 pixels in flight -> out_valid and RGB 0 immediately; coll_flags 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types, defaults and helpers for the sprite compositor.
package sprite_pkg;

  localparam int DEF_NUM_SPRITES = 8;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_HALF_MAX    = 32;

  localparam logic [7:0] BG_BLUE_BASE = 8'h7F;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit position of the (i,j) pair, i<j, in the flattened collision matrix.
  function automatic int pair_idx(input int i, input int j);
    return j * (j - 1) / 2 + i;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Texture ROM request/response bus between the compositor (master) and a synchronous ROM (slave).
interface sprite_compositor_if
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int HALF_MAX    = DEF_HALF_MAX
);
  localparam int ID_W  = $clog2(NUM_SPRITES);
  localparam int LOC_W = $clog2(2 * HALF_MAX + 1);

  logic [ID_W-1:0]  tex_id;
  logic [LOC_W-1:0] tex_row;
  logic [LOC_W-1:0] tex_col;
  rgb_t             tex_rgb;
  logic             tex_alpha;

  modport master (output tex_id, tex_row, tex_col, input  tex_rgb, tex_alpha);
  modport slave  (input  tex_id, tex_row, tex_col, output tex_rgb, tex_alpha);
endinterface

// File: rtl/sprite_hit_test.sv
// Signed bounding-box test of one sprite against the current pixel, plus the pixel's local coordinates.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int LOC_W   = 7
) (
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [LOC_W-1:0]   i_half,
  input  logic               i_en,
  output logic               o_hit,
  output logic [LOC_W-1:0]   o_col,
  output logic [LOC_W-1:0]   o_row
);
  // Two guard bits keep boxes that cross 0 or the top coordinate from wrapping.
  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] w_dx;
  logic signed [SW-1:0] w_dy;
  logic signed [SW-1:0] w_half;

  assign w_dx   = $signed({2'b00, i_draw_x}) - $signed({2'b00, i_cx});
  assign w_dy   = $signed({2'b00, i_draw_y}) - $signed({2'b00, i_cy});
  assign w_half = $signed({{(SW - LOC_W){1'b0}}, i_half});

  assign o_hit = i_en && (w_dx >= -w_half) && (w_dx <= w_half)
                      && (w_dy >= -w_half) && (w_dy <= w_half);
  assign o_col = LOC_W'(w_dx + w_half);
  assign o_row = LOC_W'(w_dy + w_half);
endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite mixer with frame-latched shadows and a 4-edge pixel pipeline.
// Optional SPRITE_COLLISION_EN adds the per-frame pairwise collision matrix.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int HALF_MAX    = DEF_HALF_MAX,
  localparam int LOC_W      = $clog2(2 * HALF_MAX + 1),
  localparam int ID_W       = $clog2(NUM_SPRITES),
  localparam int NPAIR      = NUM_SPRITES * (NUM_SPRITES - 1) / 2
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*LOC_W-1:0]   sprite_half,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [NUM_SPRITES-1:0]         sprite_tex,
  input  logic [NUM_SPRITES*24-1:0]      sprite_rgb,
  sprite_compositor_if.master            tex,
  output logic [7:0]                     Red,
  output logic [7:0]                     Green,
  output logic [7:0]                     Blue,
  output logic                           out_valid,
  output logic [NPAIR-1:0]               coll_flags,
  output logic                           coll_valid
);
  logic [COORD_W-1:0]     r_x_sh [NUM_SPRITES];
  logic [COORD_W-1:0]     r_y_sh [NUM_SPRITES];
  logic [LOC_W-1:0]       r_half_sh [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_en_sh, r_tex_sh, r_tex_d;
  rgb_t                   r_rgb_sh [NUM_SPRITES];
  rgb_t                   r_rgb_d [NUM_SPRITES];
  logic                   r_fs_p1;

  // tex/rgb are consumed one stage after the hit test, so they follow the
  // shadows one edge late to stay aligned with the pixel straddling frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fs_p1  <= 1'b0;
      r_en_sh  <= '0;
      r_tex_sh <= '0;
      r_tex_d  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_x_sh[i]    <= '0;
        r_y_sh[i]    <= '0;
        r_half_sh[i] <= '0;
        r_rgb_sh[i]  <= '0;
        r_rgb_d[i]   <= '0;
      end
    end else begin
      r_fs_p1 <= frame_start;
      if (frame_start) begin
        r_en_sh  <= sprite_en;
        r_tex_sh <= sprite_tex;
      end
      if (r_fs_p1) r_tex_d <= r_tex_sh;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (frame_start) begin
          r_x_sh[i]    <= sprite_x[i*COORD_W +: COORD_W];
          r_y_sh[i]    <= sprite_y[i*COORD_W +: COORD_W];
          r_half_sh[i] <= sprite_half[i*LOC_W +: LOC_W];
          r_rgb_sh[i]  <= rgb_t'(sprite_rgb[i*24 +: 24]);
        end
        if (r_fs_p1) r_rgb_d[i] <= r_rgb_sh[i];
      end
    end
  end

  logic [NUM_SPRITES-1:0] w_hit;
  logic [LOC_W-1:0]       w_col [NUM_SPRITES];
  logic [LOC_W-1:0]       w_row [NUM_SPRITES];

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
    sprite_hit_test #(.COORD_W(COORD_W), .LOC_W(LOC_W)) u_hit (
      .i_draw_x (DrawX),
      .i_draw_y (DrawY),
      .i_cx     (r_x_sh[gi]),
      .i_cy     (r_y_sh[gi]),
      .i_half   (r_half_sh[gi]),
      .i_en     (r_en_sh[gi]),
      .o_hit    (w_hit[gi]),
      .o_col    (w_col[gi]),
      .o_row    (w_row[gi])
    );
  end

  logic [NUM_SPRITES-1:0] r_hit_p1;
  logic [LOC_W-1:0]       r_col_p1 [NUM_SPRITES];
  logic [LOC_W-1:0]       r_row_p1 [NUM_SPRITES];
  logic [7:0]             r_bg_p1, r_bg_p2, r_bg_p3, r_bg_p4;
  logic                   r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
  logic [ID_W-1:0]        r_id_p2, r_id_p3;
  logic [LOC_W-1:0]       r_col_p2, r_row_p2, r_col_p3, r_row_p3;
  logic                   r_any_p2, r_any_p3, r_any_p4;
  logic                   r_tex_p2, r_tex_p3, r_tex_p4;
  rgb_t                   r_rgb_p2, r_rgb_p3, r_rgb_p4;
  logic [ID_W-1:0]        w_win;
  logic                   w_any;
  rgb_t                   w_mix;

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (r_hit_p1[i]) begin
        w_win = ID_W'(i);
        w_any = 1'b1;
      end
    end
  end

  // Transparent texels fall through to background, never to a lower layer.
  always_comb begin
    w_mix = '0;
    if (r_vld_p4) begin
      if (r_any_p4 && !r_tex_p4)      w_mix = r_rgb_p4;
      else if (r_any_p4 && tex.tex_alpha) w_mix = tex.tex_rgb;
      else                            w_mix.b = r_bg_p4;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit_p1 <= '0; r_bg_p1 <= '0; r_vld_p1 <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_col_p1[i] <= '0;
        r_row_p1[i] <= '0;
      end
      r_id_p2 <= '0; r_col_p2 <= '0; r_row_p2 <= '0; r_any_p2 <= 1'b0;
      r_tex_p2 <= 1'b0; r_rgb_p2 <= '0; r_bg_p2 <= '0; r_vld_p2 <= 1'b0;
      r_id_p3 <= '0; r_col_p3 <= '0; r_row_p3 <= '0; r_any_p3 <= 1'b0;
      r_tex_p3 <= 1'b0; r_rgb_p3 <= '0; r_bg_p3 <= '0; r_vld_p3 <= 1'b0;
      r_any_p4 <= 1'b0; r_tex_p4 <= 1'b0; r_rgb_p4 <= '0; r_bg_p4 <= '0; r_vld_p4 <= 1'b0;
      Red <= '0; Green <= '0; Blue <= '0; out_valid <= 1'b0;
    end else begin
      // p1: hit mask and per-sprite local coordinates
      r_hit_p1 <= w_hit;
      r_bg_p1  <= BG_BLUE_BASE - {1'b0, DrawX[9:3]};
      r_vld_p1 <= pix_valid;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_col_p1[i] <= w_col[i];
        r_row_p1[i] <= w_row[i];
      end
      // p2: priority winner
      r_id_p2  <= w_win;
      r_col_p2 <= r_col_p1[w_win];
      r_row_p2 <= r_row_p1[w_win];
      r_any_p2 <= w_any;
      r_tex_p2 <= r_tex_d[w_win];
      r_rgb_p2 <= r_rgb_d[w_win];
      r_bg_p2  <= r_bg_p1;
      r_vld_p2 <= r_vld_p1;
      // p3: texture request presented to the ROM
      r_id_p3  <= r_id_p2;  r_col_p3 <= r_col_p2; r_row_p3 <= r_row_p2;
      r_any_p3 <= r_any_p2; r_tex_p3 <= r_tex_p2; r_rgb_p3 <= r_rgb_p2;
      r_bg_p3  <= r_bg_p2;  r_vld_p3 <= r_vld_p2;
      // p4: wait for ROM data
      r_any_p4 <= r_any_p3; r_tex_p4 <= r_tex_p3; r_rgb_p4 <= r_rgb_p3;
      r_bg_p4  <= r_bg_p3;  r_vld_p4 <= r_vld_p3;
      // out: mixed pixel
      Red       <= w_mix.r;
      Green     <= w_mix.g;
      Blue      <= w_mix.b;
      out_valid <= r_vld_p4;
    end
  end

  assign tex.tex_id  = r_id_p3;
  assign tex.tex_row = r_row_p3;
  assign tex.tex_col = r_col_p3;

`ifdef SPRITE_COLLISION_EN
  logic [NPAIR-1:0] w_pairs;
  logic [NPAIR-1:0] r_acc;

  always_comb begin
    w_pairs = '0;
    for (int j = 1; j < NUM_SPRITES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (pix_valid && w_hit[i] && w_hit[j]) w_pairs[pair_idx(i, j)] = 1'b1;
      end
    end
  end

  // The pixel sharing the frame_start edge is reported now and also seeds the new frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_acc      <= '0;
      coll_flags <= '0;
      coll_valid <= 1'b0;
    end else begin
      coll_valid <= frame_start;
      if (frame_start) begin
        coll_flags <= r_acc | w_pairs;
        r_acc      <= w_pairs;
      end else begin
        r_acc      <= r_acc | w_pairs;
      end
    end
  end
`else
  assign coll_flags = '0;
  assign coll_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a behavioural synchronous texture ROM.
module tb_sprite_compositor;
  localparam int N  = 8;
  localparam int CW = 10;
  localparam int LW = 7;

`ifdef SPRITE_COLLISION_EN
  localparam logic        EXP_CV = 1'b1;
  localparam logic [27:0] EXP_CF = 28'h1;
`else
  localparam logic        EXP_CV = 1'b0;
  localparam logic [27:0] EXP_CF = 28'h0;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] DrawX = '0, DrawY = '0;
  logic [N*CW-1:0] sprite_x = '0, sprite_y = '0;
  logic [N*LW-1:0] sprite_half = '0;
  logic [N-1:0]    sprite_en = '0, sprite_tex = '0;
  logic [N*24-1:0] sprite_rgb = '0;
  logic [7:0]      Red, Green, Blue;
  logic            out_valid;
  logic [27:0]     coll_flags;
  logic            coll_valid;

  logic [23:0] rom_rgb = '0;
  logic        rom_alpha = 1'b1, rom_alpha_q = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  sprite_compositor_if #(.NUM_SPRITES(N), .HALF_MAX(32)) tif ();

  always @(posedge Clk) begin
    rom_rgb     <= {8'hC0 | {5'b0, tif.tex_id}, 1'b0, tif.tex_row, 1'b0, tif.tex_col};
    rom_alpha_q <= rom_alpha;
  end
  assign tif.tex_rgb   = rom_rgb;
  assign tif.tex_alpha = rom_alpha_q;

  sprite_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_half(sprite_half), .sprite_en(sprite_en), .sprite_tex(sprite_tex),
    .sprite_rgb(sprite_rgb), .tex(tif), .Red(Red), .Green(Green), .Blue(Blue),
    .out_valid(out_valid), .coll_flags(coll_flags), .coll_valid(coll_valid)
  );

  task automatic set_sprite(input int i, input int x, input int y, input int half,
                            input logic en, input logic tx, input logic [23:0] rgb);
    logic [31:0] xv, yv, hv;
    xv = x; yv = y; hv = half;
    sprite_x[i*CW +: CW]    = xv[CW-1:0];
    sprite_y[i*CW +: CW]    = yv[CW-1:0];
    sprite_half[i*LW +: LW] = hv[LW-1:0];
    sprite_en[i]            = en;
    sprite_tex[i]           = tx;
    sprite_rgb[i*24 +: 24]  = rgb;
  endtask

  task automatic do_frame();
    @(negedge Clk); frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
    @(negedge Clk);
  endtask

  // One isolated pixel; samples the texture request at n+2 and the output at n+3 and n+4.
  task automatic run_pix(input int x, input int y, output logic [2:0] tid,
                         output logic [6:0] trow, output logic [6:0] tcol,
                         output logic ov_e, output logic ov, output logic [23:0] rgb);
    logic [31:0] xv, yv;
    xv = x; yv = y;
    @(negedge Clk); DrawX = xv[CW-1:0]; DrawY = yv[CW-1:0]; pix_valid = 1'b1;
    @(negedge Clk); pix_valid = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    tid = tif.tex_id; trow = tif.tex_row; tcol = tif.tex_col;
    @(posedge Clk); #1;
    ov_e = out_valid;
    @(posedge Clk); #1;
    ov = out_valid; rgb = {Red, Green, Blue};
  endtask

  logic [2:0]  tid;
  logic [6:0]  trow, tcol;
  logic        ov_e, ov;
  logic [23:0] rgb;

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_checks++; if ({Red, Green, Blue} !== 24'h0) begin n_fail++; $display("FAIL rst_rgb got=%h exp=000000", {Red, Green, Blue}); end
    n_checks++; if ({tif.tex_id, tif.tex_row, tif.tex_col} !== 17'h0) begin n_fail++; $display("FAIL rst_tex got=%h exp=0", {tif.tex_id, tif.tex_row, tif.tex_col}); end
    n_checks++; if (coll_flags !== 28'h0 || coll_valid !== 1'b0) begin n_fail++; $display("FAIL rst_coll got=%h/%b exp=0/0", coll_flags, coll_valid); end
    Reset_n = 1'b1;
  endtask

  task automatic test_background();
    run_pix(80, 0, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (ov_e !== 1'b0) begin n_fail++; $display("FAIL bg_latency_early got=%b exp=0", ov_e); end
    n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL bg_valid got=%b exp=1", ov); end
    n_checks++; if (rgb !== 24'h000075) begin n_fail++; $display("FAIL bg_rgb got=%h exp=000075", rgb); end
  endtask

  task automatic test_solid();
    set_sprite(0, 100, 100, 2, 1'b1, 1'b0, 24'hFFFFFF);
    do_frame();
    run_pix(102, 98, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL solid_edge got=%h exp=FFFFFF", rgb); end
    n_checks++; if (tid !== 3'd0 || tcol !== 7'd4 || trow !== 7'd0) begin n_fail++; $display("FAIL solid_tex got id=%0d row=%0d col=%0d exp 0/0/4", tid, trow, tcol); end
    run_pix(103, 98, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h000073) begin n_fail++; $display("FAIL solid_outside got=%h exp=000073", rgb); end
    run_pix(98, 102, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL solid_corner got=%h exp=FFFFFF", rgb); end
  endtask

  task automatic test_overlap();
    set_sprite(0, 50, 50, 3, 1'b1, 1'b0, 24'h112233);
    set_sprite(1, 50, 50, 4, 1'b1, 1'b0, 24'h445566);
    do_frame();
    run_pix(50, 50, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (tid !== 3'd0) begin n_fail++; $display("FAIL ovl_prio_id got=%0d exp=0", tid); end
    n_checks++; if (rgb !== 24'h112233) begin n_fail++; $display("FAIL ovl_prio_rgb got=%h exp=112233", rgb); end
    run_pix(54, 50, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (tid !== 3'd1 || tcol !== 7'd8 || trow !== 7'd4) begin n_fail++; $display("FAIL ovl_lower got id=%0d row=%0d col=%0d exp 1/4/8", tid, trow, tcol); end
    n_checks++; if (rgb !== 24'h445566) begin n_fail++; $display("FAIL ovl_lower_rgb got=%h exp=445566", rgb); end
    @(negedge Clk); frame_start = 1'b1;
    @(posedge Clk); #1;
    n_checks++; if (coll_valid !== EXP_CV) begin n_fail++; $display("FAIL coll_pulse got=%b exp=%b", coll_valid, EXP_CV); end
    n_checks++; if (coll_flags !== EXP_CF) begin n_fail++; $display("FAIL coll_flags got=%h exp=%h", coll_flags, EXP_CF); end
    @(negedge Clk); frame_start = 1'b0;
    @(posedge Clk); #1;
    n_checks++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL coll_single_pulse got=%b exp=0", coll_valid); end
    n_checks++; if (coll_flags !== EXP_CF) begin n_fail++; $display("FAIL coll_flags_hold got=%h exp=%h", coll_flags, EXP_CF); end
  endtask

  task automatic test_texture();
    set_sprite(0, 0, 0, 0, 1'b0, 1'b0, 24'h0);
    set_sprite(1, 0, 0, 0, 1'b0, 1'b0, 24'h0);
    set_sprite(2, 5, 5, 32, 1'b1, 1'b1, 24'h123456);
    do_frame();
    rom_alpha = 1'b1;
    run_pix(0, 0, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (tid !== 3'd2 || trow !== 7'd27 || tcol !== 7'd27) begin n_fail++; $display("FAIL tex_nowrap got id=%0d row=%0d col=%0d exp 2/27/27", tid, trow, tcol); end
    n_checks++; if (rgb !== 24'hC21B1B) begin n_fail++; $display("FAIL tex_opaque got=%h exp=C21B1B", rgb); end
    run_pix(37, 0, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'hC21B40) begin n_fail++; $display("FAIL tex_right_edge got=%h exp=C21B40", rgb); end
    run_pix(38, 0, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h00007B) begin n_fail++; $display("FAIL tex_past_edge got=%h exp=00007B", rgb); end
    rom_alpha = 1'b0;
    run_pix(0, 0, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h00007F) begin n_fail++; $display("FAIL tex_transparent got=%h exp=00007F", rgb); end
    rom_alpha = 1'b1;
  endtask

  task automatic test_no_tearing();
    set_sprite(2, 0, 0, 0, 1'b0, 1'b0, 24'h0);
    set_sprite(0, 200, 200, 5, 1'b1, 1'b0, 24'h00FF00);
    do_frame();
    run_pix(200, 200, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL tear_before got=%h exp=00FF00", rgb); end
    set_sprite(0, 400, 200, 5, 1'b1, 1'b0, 24'h00FF00);
    run_pix(200, 200, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL tear_old_pos got=%h exp=00FF00", rgb); end
    run_pix(400, 200, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h00004D) begin n_fail++; $display("FAIL tear_new_pos_early got=%h exp=00004D", rgb); end
    do_frame();
    run_pix(200, 200, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h000066) begin n_fail++; $display("FAIL tear_old_after got=%h exp=000066", rgb); end
    run_pix(400, 200, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL tear_new_after got=%h exp=00FF00", rgb); end
  endtask

  task automatic test_back_to_back();
    int          px [4]    = '{400, 0, 80, 401};
    logic        pv [4]    = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [23:0] erg [4]   = '{24'h00FF00, 24'h000000, 24'h000075, 24'h00FF00};
    logic [31:0] xv;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      xv = px[k];
      DrawX = xv[CW-1:0]; DrawY = 10'd200; pix_valid = pv[k];
    end
    @(negedge Clk); pix_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      n_checks++; if (out_valid !== pv[k]) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", k, out_valid, pv[k]); end
      n_checks++; if ({Red, Green, Blue} !== erg[k]) begin n_fail++; $display("FAIL b2b_rgb[%0d] got=%h exp=%h", k, {Red, Green, Blue}, erg[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk); DrawX = 10'd400; DrawY = 10'd200; pix_valid = 1'b1;
    end
    @(negedge Clk);
    n_checks++; if (out_valid !== 1'b1 || {Red, Green, Blue} !== 24'h00FF00) begin n_fail++; $display("FAIL mid_pre got=%b/%h exp=1/00FF00", out_valid, {Red, Green, Blue}); end
    Reset_n = 1'b0; pix_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || {Red, Green, Blue} !== 24'h0) begin n_fail++; $display("FAIL mid_async_clear got=%b/%h exp=0/000000", out_valid, {Red, Green, Blue}); end
    n_checks++; if (coll_flags !== 28'h0) begin n_fail++; $display("FAIL mid_coll got=%h exp=0", coll_flags); end
    repeat (2) @(posedge Clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || tif.tex_col !== 7'd0) begin n_fail++; $display("FAIL mid_hold got=%b/%0d exp=0/0", out_valid, tif.tex_col); end
    @(negedge Clk); Reset_n = 1'b1;
    run_pix(400, 200, tid, trow, tcol, ov_e, ov, rgb);
    n_checks++; if (ov_e !== 1'b0 || ov !== 1'b1) begin n_fail++; $display("FAIL mid_resume_latency got=%b%b exp=01", ov_e, ov); end
    n_checks++; if (rgb !== 24'h00004D) begin n_fail++; $display("FAIL mid_shadow_cleared got=%h exp=00004D", rgb); end
  endtask

  initial begin
    test_reset();
    test_background();
    test_solid();
    test_overlap();
    test_texture();
    test_no_tearing();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
